// File: rtl/lock_code_sender.sv
// rtl/lock_code_sender.sv - sends a latched symbol code to a lock, retrying until unlock or MAX_TRIES
module lock_code_sender #(
  parameter int CODE_LEN    = 4,
  parameter int SYM_HOLD    = 1,
  parameter int WAIT_CYCLES = 2,
  parameter int MAX_TRIES   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*CODE_LEN-1:0] code,
  input  logic                  unlock,
  output logic                  x,
  output logic                  y,
  output logic                  busy,
  output logic                  done,
  output logic                  success,
  output logic                  fail,
  output logic [3:0]            attempts
);

  typedef enum logic [2:0] {IDLE, CLEAR, SEND, WAIT, DONE} state_t;

  state_t                state_q, state_n;
  logic [2*CODE_LEN-1:0] code_q, code_n;
  logic [3:0]            sym_idx_q, sym_idx_n;
  logic [15:0]           hold_cnt_q, hold_cnt_n;
  logic [15:0]           wait_cnt_q, wait_cnt_n;
  logic [3:0]            attempts_q, attempts_n;
  logic                  success_q, success_n;
  logic                  fail_q, fail_n;
  logic [2*CODE_LEN-1:0] sym_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      code_q     <= '0;
      sym_idx_q  <= '0;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      attempts_q <= '0;
      success_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      code_q     <= code_n;
      sym_idx_q  <= sym_idx_n;
      hold_cnt_q <= hold_cnt_n;
      wait_cnt_q <= wait_cnt_n;
      attempts_q <= attempts_n;
      success_q  <= success_n;
      fail_q     <= fail_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    code_n     = code_q;
    sym_idx_n  = sym_idx_q;
    hold_cnt_n = hold_cnt_q;
    wait_cnt_n = wait_cnt_q;
    attempts_n = attempts_q;
    success_n  = success_q;
    fail_n     = fail_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          code_n     = code;
          success_n  = 1'b0;
          fail_n     = 1'b0;
          attempts_n = 4'd1;
          state_n    = CLEAR;
        end
      end
      CLEAR: begin
        sym_idx_n  = '0;
        hold_cnt_n = '0;
        state_n    = SEND;
      end
      SEND: begin
        if (hold_cnt_q == 16'(SYM_HOLD - 1)) begin
          hold_cnt_n = '0;
          if (sym_idx_q == 4'(CODE_LEN - 1)) begin
            wait_cnt_n = '0;
            state_n    = WAIT;
          end else begin
            sym_idx_n = sym_idx_q + 4'd1;
          end
        end else begin
          hold_cnt_n = hold_cnt_q + 16'd1;
        end
      end
      WAIT: begin
        if (unlock) begin
          success_n = 1'b1;
          state_n   = DONE;
        end else if (wait_cnt_q == 16'(WAIT_CYCLES - 1)) begin
          if (attempts_q == 4'(MAX_TRIES)) begin
            fail_n  = 1'b1;
            state_n = DONE;
          end else begin
            attempts_n = attempts_q + 4'd1;
            state_n    = CLEAR;
          end
        end else begin
          wait_cnt_n = wait_cnt_q + 16'd1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Symbol i lives at code_q[2i+1:2i]; shift it down to the low two bits.
  assign sym_shift = code_q >> {sym_idx_q, 1'b0};

  always_comb begin
    x    = 1'b0;
    y    = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      CLEAR: begin
        y    = 1'b1;
        busy = 1'b1;
      end
      SEND: begin
        x    = sym_shift[1];
        y    = sym_shift[0];
        busy = 1'b1;
      end
      WAIT: busy = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign success  = success_q;
  assign fail     = fail_q;
  assign attempts = attempts_q;

endmodule
